// File: rtl/object_store_if.sv
// Client request/done bus between the rope controller (master) and object_store (slave).
interface object_store_if;
    logic        read_req;
    logic        write_req;
    logic [3:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        read_done;
    logic        write_done;
    logic        busy;

    modport master (
        output read_req, write_req, address, write_data,
        input  read_data, read_done, write_done, busy
    );

    modport slave (
        input  read_req, write_req, address, write_data,
        output read_data, read_done, write_done, busy
    );
endinterface

// File: rtl/object_store.sv
// Sixteen-entry 32-bit object table with fixed-latency request/done client port.
// Optional registered drawing read port enabled by OBJECT_STORE_DRAW_PORT_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_INIT    | writing INIT_WORD to entries 0..15, one per cycle
// S_IDLE    | sampling read_req/write_req each edge
// S_RBUSY   | read accepted, counting LATENCY, loads read_data at the end
// S_WBUSY   | write accepted, counting LATENCY, commits to array at the end
// S_RECOVER | single dead cycle after a done pulse, requests ignored
module object_store #(
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] INIT_WORD = 32'h0
) (
    input  logic                 clock,
    input  logic                 reset,
    object_store_if.slave        bus
`ifdef OBJECT_STORE_DRAW_PORT_EN
    ,
    input  logic [3:0]           draw_addr,
    output logic [31:0]          draw_data
`endif
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RBUSY,
        S_WBUSY,
        S_RECOVER
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] read_data_q, read_data_d;
    logic        read_done_q, read_done_d;
    logic        write_done_q, write_done_d;
    logic        busy_q, busy_d;

    logic [31:0] mem_q [16];
    logic        mem_we;
    logic [3:0]  mem_waddr;
    logic [31:0] mem_wdata;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        read_data_d  = read_data_q;
        read_done_d  = 1'b0;
        write_done_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = cnt_q;
        mem_wdata    = INIT_WORD;

        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'hF) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            S_IDLE: begin
                // Write has priority; a simultaneous read is dropped, not queued.
                if (bus.write_req) begin
                    addr_d  = bus.address;
                    wdata_d = bus.write_data;
                    cnt_d   = LAT_M1;
                    state_d = S_WBUSY;
                end else if (bus.read_req) begin
                    addr_d  = bus.address;
                    cnt_d   = LAT_M1;
                    state_d = S_RBUSY;
                end
            end
            S_RBUSY: begin
                if (cnt_q == 4'd0) begin
                    read_data_d = mem_q[addr_q];
                    read_done_d = 1'b1;
                    state_d     = S_RECOVER;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WBUSY: begin
                if (cnt_q == 4'd0) begin
                    mem_we       = 1'b1;
                    mem_waddr    = addr_q;
                    mem_wdata    = wdata_q;
                    write_done_d = 1'b1;
                    state_d      = S_RECOVER;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RECOVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = 4'd0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_INIT;
            cnt_q        <= 4'd0;
            addr_q       <= 4'd0;
            wdata_q      <= 32'h0;
            read_data_q  <= 32'h0;
            read_done_q  <= 1'b0;
            write_done_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            read_data_q  <= read_data_d;
            read_done_q  <= read_done_d;
            write_done_q <= write_done_d;
            busy_q       <= busy_d;
        end
    end

    // Array contents need no reset: INIT rewrites every entry after reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.read_data  = read_data_q;
    assign bus.read_done  = read_done_q;
    assign bus.write_done = write_done_q;
    assign bus.busy       = busy_q;

`ifdef OBJECT_STORE_DRAW_PORT_EN
    logic [31:0] draw_data_q, draw_data_d;

    // Samples the pre-edge array, so a same-edge client write shows up one cycle later.
    always_comb begin
        draw_data_d = mem_q[draw_addr];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            draw_data_q <= 32'h0;
        end else begin
            draw_data_q <= draw_data_d;
        end
    end

    assign draw_data = draw_data_q;
`endif

endmodule

// File: tb/tb_object_store.sv
// Self-checking bench for object_store: directed scenarios plus random traffic against an array model.
module tb_object_store;
    localparam int LAT = 2;

    logic clock;
    logic reset;
    object_store_if bus();
`ifdef OBJECT_STORE_DRAW_PORT_EN
    logic [3:0]  draw_addr;
    logic [31:0] draw_data;
`endif

    object_store #(.LATENCY(LAT), .INIT_WORD(32'h0)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave)
`ifdef OBJECT_STORE_DRAW_PORT_EN
        ,
        .draw_addr (draw_addr),
        .draw_data (draw_data)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [16];
    logic [31:0] last_read;

    int          rd_cnt, wr_cnt, rd_k, wr_k, busy_bad;
    logic [31:0] rdata_seen;
    logic [31:0] draw_at_commit, draw_after;

    // Drives one request at the next edge and observes LAT+4 cycles of response.
    task automatic issue(input logic rd, input logic wr, input logic [3:0] a,
                         input logic [31:0] d, input bit hold);
        rd_cnt = 0; wr_cnt = 0; rd_k = -1; wr_k = -1; busy_bad = 0;
        rdata_seen = 32'hx; draw_at_commit = 32'hx; draw_after = 32'hx;
        @(negedge clock);
        bus.read_req = rd; bus.write_req = wr; bus.address = a; bus.write_data = d;
        @(posedge clock);
        @(negedge clock);
        if (bus.busy !== 1'b1) busy_bad++;
        if (!hold) begin bus.read_req = 1'b0; bus.write_req = 1'b0; end
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clock);
            if (bus.read_done === 1'b1) begin
                rd_cnt++;
                if (rd_k < 0) begin rd_k = k; rdata_seen = bus.read_data; end
            end
            if (bus.write_done === 1'b1) begin
                wr_cnt++;
                if (wr_k < 0) wr_k = k;
            end
            if (bus.busy !== ((k <= LAT) ? 1'b1 : 1'b0)) busy_bad++;
`ifdef OBJECT_STORE_DRAW_PORT_EN
            if (k == LAT) draw_at_commit = draw_data;
            if (k == LAT + 1) draw_after = draw_data;
`endif
            if (hold && k == LAT + 1) begin bus.read_req = 1'b0; bus.write_req = 1'b0; end
        end
    endtask

    task automatic test_reset();
        int rd_seen;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (bus.read_data !== 32'h0 || bus.read_done !== 1'b0 || bus.write_done !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd=%h rdone=%b wdone=%b busy=%b, want 0/0/0/1",
                     bus.read_data, bus.read_done, bus.write_done, bus.busy);
        end
`ifdef OBJECT_STORE_DRAW_PORT_EN
        n_checks++;
        if (draw_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_draw: got %h want 0", draw_data);
        end
`endif
        reset = 1'b0;
        rd_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (bus.read_done === 1'b1) rd_seen++;
            if (i <= 16) begin
                n_checks++;
                if (bus.busy !== ((i < 16) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL init_busy: cycle %0d got %b want %b", i, bus.busy, (i < 16));
                end
            end
            if (i == 2) begin bus.read_req = 1'b1; bus.address = 4'd5; end
            if (i == 3) bus.read_req = 1'b0;
        end
        n_checks++;
        if (rd_seen != 0) begin
            n_fail++;
            $display("FAIL init_read_ignored: got %0d read_done pulses want 0", rd_seen);
        end
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        last_read = 32'h0;
        issue(1'b1, 1'b0, 4'd9, 32'h0, 1'b0);
        n_checks++;
        if (rd_cnt != 1 || rd_k != LAT || rdata_seen !== model[9]) begin
            n_fail++;
            $display("FAIL post_init_read: got cnt=%0d k=%0d data=%h want 1/%0d/%h",
                     rd_cnt, rd_k, rdata_seen, LAT, model[9]);
        end
        last_read = model[9];
    endtask

    task automatic test_write_read();
        issue(1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0);
        n_checks++;
        if (wr_cnt != 1 || wr_k != LAT || rd_cnt != 0 || busy_bad != 0) begin
            n_fail++;
            $display("FAIL write_timing: got wcnt=%0d k=%0d rcnt=%0d busy_bad=%0d want 1/%0d/0/0",
                     wr_cnt, wr_k, rd_cnt, busy_bad, LAT);
        end
        model[3] = 32'hDEAD_BEEF;
        n_checks++;
        if (bus.read_data !== last_read) begin
            n_fail++;
            $display("FAIL read_data_held: got %h want %h", bus.read_data, last_read);
        end
        issue(1'b1, 1'b0, 4'd3, 32'h0, 1'b0);
        n_checks++;
        if (rd_cnt != 1 || rd_k != LAT || rdata_seen !== model[3] || busy_bad != 0) begin
            n_fail++;
            $display("FAIL read_after_write: got cnt=%0d k=%0d data=%h busy_bad=%0d want 1/%0d/%h/0",
                     rd_cnt, rd_k, rdata_seen, busy_bad, LAT, model[3]);
        end
        last_read = model[3];
    endtask

    task automatic test_simultaneous();
        issue(1'b1, 1'b1, 4'd7, 32'h1, 1'b0);
        n_checks++;
        if (wr_cnt != 1 || rd_cnt != 0) begin
            n_fail++;
            $display("FAIL simul_write_wins: got wcnt=%0d rcnt=%0d want 1/0", wr_cnt, rd_cnt);
        end
        model[7] = 32'h1;
        issue(1'b1, 1'b0, 4'd7, 32'h0, 1'b0);
        n_checks++;
        if (rd_cnt != 1 || rdata_seen !== 32'h1) begin
            n_fail++;
            $display("FAIL simul_reissue_read: got cnt=%0d data=%h want 1/00000001", rd_cnt, rdata_seen);
        end
        last_read = model[7];
    endtask

    task automatic test_held_read();
        issue(1'b1, 1'b0, 4'd3, 32'h0, 1'b1);
        n_checks++;
        if (rd_cnt != 1 || rd_k != LAT || rdata_seen !== model[3]) begin
            n_fail++;
            $display("FAIL held_read: got cnt=%0d k=%0d data=%h want 1/%0d/%h",
                     rd_cnt, rd_k, rdata_seen, LAT, model[3]);
        end
        last_read = model[3];
    endtask

`ifdef OBJECT_STORE_DRAW_PORT_EN
    task automatic test_draw_port();
        logic [31:0] old_val;
        old_val = model[3];
        draw_addr = 4'd3;
        issue(1'b0, 1'b1, 4'd3, 32'hAB, 1'b0);
        model[3] = 32'hAB;
        n_checks++;
        if (draw_at_commit !== old_val || draw_after !== 32'hAB) begin
            n_fail++;
            $display("FAIL draw_rbw: got %h then %h want %h then 000000ab",
                     draw_at_commit, draw_after, old_val);
        end
    endtask
`endif

    task automatic test_reset_mid_write();
        int wd_seen;
        wd_seen = 0;
        @(negedge clock);
        bus.write_req = 1'b1; bus.address = 4'd2; bus.write_data = 32'h55;
        @(posedge clock);
        @(negedge clock);
        bus.write_req = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (bus.write_done === 1'b1) wd_seen++;
        end
        n_checks++;
        if (bus.read_data !== 32'h0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_outputs: got rd=%h busy=%b want 0/1", bus.read_data, bus.busy);
        end
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            if (bus.write_done === 1'b1) wd_seen++;
        end
        n_checks++;
        if (wd_seen != 0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got %0d write_done pulses busy=%b want 0/0", wd_seen, bus.busy);
        end
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        last_read = 32'h0;
        issue(1'b1, 1'b0, 4'd2, 32'h0, 1'b0);
        n_checks++;
        if (rd_cnt != 1 || rdata_seen !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_reinit: got cnt=%0d data=%h want 1/00000000", rd_cnt, rdata_seen);
        end
    endtask

    task automatic test_random();
        logic        rd, wr;
        logic [3:0]  a;
        logic [31:0] d;
        for (int n = 0; n < 30; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            issue(rd, wr, a, d, 1'($urandom_range(0, 1)) & rd & ~wr);
            if (wr) begin
                model[a] = d;
                n_checks++;
                if (wr_cnt != 1 || wr_k != LAT || rd_cnt != 0 || busy_bad != 0 || bus.read_data !== last_read) begin
                    n_fail++;
                    $display("FAIL rand_write[%0d]: got wcnt=%0d k=%0d rcnt=%0d busy_bad=%0d rd=%h want 1/%0d/0/0/%h",
                             n, wr_cnt, wr_k, rd_cnt, busy_bad, bus.read_data, LAT, last_read);
                end
            end else begin
                n_checks++;
                if (rd_cnt != 1 || rd_k != LAT || wr_cnt != 0 || busy_bad != 0 || rdata_seen !== model[a]) begin
                    n_fail++;
                    $display("FAIL rand_read[%0d]: addr %0d got cnt=%0d k=%0d data=%h busy_bad=%0d want 1/%0d/%h/0",
                             n, a, rd_cnt, rd_k, rdata_seen, busy_bad, LAT, model[a]);
                end
                last_read = model[a];
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.read_req = 1'b0; bus.write_req = 1'b0;
        bus.address = 4'd0; bus.write_data = 32'h0;
`ifdef OBJECT_STORE_DRAW_PORT_EN
        draw_addr = 4'd0;
`endif
        test_reset();
        test_write_read();
        test_simultaneous();
        test_held_read();
`ifdef OBJECT_STORE_DRAW_PORT_EN
        test_draw_port();
`endif
        test_random();
        test_reset_mid_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
